sync_fifo_fwft: RTL and testbench

//  Parametrised synchronous FIFO, first-word-fall-through, valid/ready on both sides.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/dual_port_ram.sv | 25 ++
 rtl/sync_fifo_fwft.sv | 132 +++++++++++++
 tb/tb_sync_fifo_fwft.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and width helpers for sync_fifo_fwft.
package fifo_pkg;

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    function automatic int cnt_w(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM, one write port, one read port with 1-clk registered read.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO, registered-read RAM plus 2-entry prefetch buffer.
// Optional SYNC_FIFO_HWM_EN adds an hwm output tracking the peak count.
module sync_fifo_fwft
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         rd_valid,
    input  logic                         rd_ready,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic [cnt_w(ADDR_WIDTH)-1:0] count,
    input  logic [cnt_w(ADDR_WIDTH)-1:0] almost_full_th,
    input  logic [cnt_w(ADDR_WIDTH)-1:0] almost_empty_th,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow,
`ifdef SYNC_FIFO_HWM_EN
    output logic [cnt_w(ADDR_WIDTH)-1:0] hwm,
`endif
    input  logic                         err_clr
);

    localparam int CW = cnt_w(ADDR_WIDTH);
    localparam logic [CW-1:0] DEPTH = CW'(2**ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count, r_ram_cnt;
    logic [1:0]            r_pf_occ;
    logic                  r_inflight;
    logic [DATA_WIDTH-1:0] r_pf0, r_pf1;
    fifo_err_t             r_err;

    logic                  w_push, w_pop, w_fetch;
    logic [1:0]            w_occ_pop;
    logic [2:0]            w_pend;
    logic [DATA_WIDTH-1:0] w_ram_q;
    fifo_err_t             w_err_new;

    assign full         = r_count == DEPTH;
    assign empty        = r_count == '0;
    assign wr_ready     = !full;
    assign rd_valid     = r_pf_occ != 2'd0;
    assign rd_data      = r_pf0;
    assign count        = r_count;
    assign almost_full  = r_count >= almost_full_th;
    assign almost_empty = r_count <= almost_empty_th;
    assign overflow     = r_err.overflow;
    assign underflow    = r_err.underflow;

    assign w_push    = wr_valid && wr_ready && !flush;
    assign w_pop     = rd_valid && rd_ready && !flush;
    assign w_occ_pop = r_pf_occ - {1'b0, w_pop};
    // Slots already claimed after this cycle's pop; keep at most two words buffered or in flight.
    assign w_pend    = {1'b0, w_occ_pop} + {2'b00, r_inflight};
    assign w_fetch   = !flush && (r_ram_cnt != '0) && (w_pend < 3'd2);
    assign w_err_new = '{overflow: wr_valid && !wr_ready, underflow: rd_ready && !rd_valid};

    dual_port_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .i_we   (w_push),
        .i_waddr(r_wr_ptr),
        .i_wdata(wr_data),
        .i_re   (w_fetch),
        .i_raddr(r_rd_ptr),
        .o_rdata(w_ram_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ram_cnt  <= '0;
            r_pf_occ   <= '0;
            r_inflight <= 1'b0;
            r_pf0      <= '0;
            r_pf1      <= '0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ram_cnt  <= '0;
            r_pf_occ   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_wr_ptr   <= r_wr_ptr + ADDR_WIDTH'(w_push);
            r_rd_ptr   <= r_rd_ptr + ADDR_WIDTH'(w_fetch);
            r_count    <= r_count + CW'(w_push) - CW'(w_pop);
            r_ram_cnt  <= r_ram_cnt + CW'(w_push) - CW'(w_fetch);
            r_inflight <= w_fetch;
            r_pf_occ   <= w_occ_pop + {1'b0, r_inflight};
            // A landing read fills the first free slot after the pop shift.
            r_pf0      <= (r_inflight && w_occ_pop == 2'd0) ? w_ram_q : w_pop ? r_pf1 : r_pf0;
            r_pf1      <= (r_inflight && w_occ_pop == 2'd1) ? w_ram_q : r_pf1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            r_err.overflow  <= (r_err.overflow && !err_clr) || w_err_new.overflow;
            r_err.underflow <= (r_err.underflow && !err_clr) || w_err_new.underflow;
        end
    end

`ifdef SYNC_FIFO_HWM_EN
    logic [CW-1:0] r_hwm;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_hwm <= '0;
        else if (flush || err_clr) r_hwm <= '0;
        else r_hwm <= (r_count > r_hwm) ? r_count : r_hwm;
    end

    assign hwm = r_hwm;
`endif

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// tb_sync_fifo_fwft: queue-based reference model checked every cycle, plus directed literal checks.
module tb_sync_fifo_fwft;

    localparam int DEPTH = 16;

    logic       clk = 1'b0, rst = 1'b1, flush = 1'b0, wr_valid = 1'b0, rd_ready = 1'b0, err_clr = 1'b0;
    logic [7:0] wr_data = '0;
    logic [4:0] af_th = 5'd12, ae_th = 5'd4;
    logic       wr_ready, rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [7:0] rd_data;
    logic [4:0] count;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .count(count), .almost_full_th(af_th), .almost_empty_th(ae_th),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow), .err_clr(err_clr)
    );

    typedef struct { logic [7:0] d; int t; } ent_t;
    ent_t mq[$];
    int   k = 0;
    bit   m_ovf = 0, m_unf = 0;
    int   compared = 0, mismatched = 0;
    bit   chk_en = 0;

    // A word pushed at edge t is visible at the head from edge t+2 onward.
    function automatic bit m_rv();
        return mq.size() > 0 && (k - mq[0].t) >= 2;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    int mc;
    bit mrv, mpush, mpop, movf, munf;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_ovf = 0;
            m_unf = 0;
        end else begin
            mc    = mq.size();
            mrv   = m_rv();
            mpush = wr_valid && mc < DEPTH && !flush;
            mpop  = rd_ready && mrv && !flush;
            movf  = wr_valid && mc == DEPTH;
            munf  = rd_ready && !mrv;
            k++;
            if (flush) mq.delete();
            else begin
                if (mpop) void'(mq.pop_front());
                if (mpush) mq.push_back('{wr_data, k});
            end
            m_ovf = (m_ovf && !err_clr) || movf;
            m_unf = (m_unf && !err_clr) || munf;
        end
    end

    int cc;
    bit crv;
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            cc  = mq.size();
            crv = m_rv();
            chk("rd_valid", rd_valid, crv);
            if (crv) chk("rd_data", rd_data, mq[0].d);
            chk("count", count, cc);
            chk("full", full, cc == DEPTH);
            chk("empty", empty, cc == 0);
            chk("wr_ready", wr_ready, cc != DEPTH);
            chk("almost_full", almost_full, cc >= int'(af_th));
            chk("almost_empty", almost_empty, cc <= int'(ae_th));
            chk("overflow", overflow, m_ovf);
            chk("underflow", underflow, m_unf);
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_v, pushed, popped, maxc;
        step();
        step();
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_wr_ready", wr_ready, 1);
        chk("rst_flags", {overflow, underflow}, 0);
        rst = 1'b0;
        chk_en = 1;
        step();

        // first-word latency
        wr_valid = 1; wr_data = 8'hA5;
        step();
        wr_valid = 0;
        chk("t1_rv_T", rd_valid, 0);
        chk("t1_count_T", count, 1);
        step();
        chk("t1_rv_T1", rd_valid, 0);
        step();
        chk("t1_rv_T2", rd_valid, 1);
        chk("t1_data", rd_data, 8'hA5);
        chk("t1_count", count, 1);
        chk("t1_empty", empty, 0);
        rd_ready = 1;
        step();
        rd_ready = 0;
        chk("t1_empty_after_pop", empty, 1);

        // fill to full, overflow, drain in order
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1; wr_data = 8'(i);
            step();
        end
        chk("t2_full", full, 1);
        chk("t2_wr_ready", wr_ready, 0);
        chk("t2_count", count, 16);
        wr_data = 8'h99;
        step();
        wr_valid = 0;
        chk("t2_overflow", overflow, 1);
        chk("t2_count_after_ovf", count, 16);
        rd_ready = 1;
        exp_v = 0;
        for (int n = 0; n < 100 && exp_v < 16; n++) begin
            if (rd_valid) begin
                chk("t2_drain", rd_data, exp_v);
                exp_v++;
            end
            step();
        end
        rd_ready = 0;
        chk("t2_drained_words", exp_v, 16);
        step();
        chk("t2_empty", empty, 1);
        err_clr = 1;
        step();
        err_clr = 0;
        chk("t2_err_clr", overflow, 0);

        // threshold crossings
        for (int i = 1; i <= 12; i++) begin
            wr_valid = 1; wr_data = 8'(8'h40 + i);
            step();
            wr_valid = 0;
            if (i == 4) begin chk("t4_ae_at4", almost_empty, 1); chk("t4_af_at4", almost_full, 0); end
            if (i == 5) chk("t4_ae_at5", almost_empty, 0);
            if (i == 11) chk("t4_af_at11", almost_full, 0);
            if (i == 12) chk("t4_af_at12", almost_full, 1);
        end
        flush = 1;
        step();
        flush = 0;
        chk("t4_flush_count", count, 0);

        // flush with a read in flight
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1; wr_data = 8'(8'h80 + i);
            step();
        end
        wr_valid = 0; rd_ready = 1;
        step();
        rd_ready = 0;
        chk("t5_count7", count, 7);
        flush = 1; wr_valid = 1; wr_data = 8'hEE;
        step();
        flush = 0; wr_valid = 0;
        chk("t5_count0", count, 0);
        chk("t5_empty", empty, 1);
        chk("t5_rv0", rd_valid, 0);
        step();
        step();
        chk("t5_rv_stays0", rd_valid, 0);
        wr_valid = 1; wr_data = 8'h3C;
        step();
        wr_valid = 0;
        step();
        step();
        chk("t5_rv", rd_valid, 1);
        chk("t5_data", rd_data, 8'h3C);
        rd_ready = 1;
        step();
        rd_ready = 0;

        // random-rate streaming
        pushed = 0; popped = 0; maxc = 0;
        for (int n = 0; n < 6000 && popped < 1000; n++) begin
            wr_valid = pushed < 1000;
            wr_data  = 8'(pushed);
            rd_ready = 1'($urandom_range(0, 1));
            if (rd_valid && rd_ready) chk("t3_order", rd_data, popped & 8'hFF);
            if (wr_valid && wr_ready) pushed++;
            if (rd_valid && rd_ready) popped++;
            step();
            if (int'(count) > maxc) maxc = int'(count);
        end
        wr_valid = 0; rd_ready = 0;
        chk("t3_popped", popped, 1000);
        chk("t3_max_count_le16", maxc <= 16, 1);
        step();
        chk("t3_empty", empty, 1);

        // underflow, err_clr, set-wins, reset mid-stream
        rd_ready = 1;
        step();
        rd_ready = 0;
        chk("t6_underflow", underflow, 1);
        err_clr = 1; rd_ready = 1;
        step();
        rd_ready = 0;
        chk("t6_set_wins", underflow, 1);
        step();
        err_clr = 0;
        chk("t6_cleared", underflow, 0);
        chk("t6_ovf_cleared", overflow, 0);
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1; wr_data = 8'(8'hC0 + i); rd_ready = 1;
            step();
        end
        rst = 1;
        #1;
        wr_valid = 0; rd_ready = 0;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_rv", rd_valid, 0);
        chk("t6_rst_data", rd_data, 0);
        chk("t6_rst_empty", empty, 1);
        chk("t6_rst_wr_ready", wr_ready, 1);
        chk("t6_rst_flags", {overflow, underflow}, 0);
        step();
        rst = 0;
        step();
        chk("t6_post_rst_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
